// File: rtl/link_pkg.sv
// Shared types for the link arbiter: FSM state encoding and width helpers.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    RELEASE = 2'd3
  } link_state_e;

  localparam int DW_DEFAULT = 8;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/link_rr_pick.sv
// Round-robin picker: first set request scanning from ptr_i upward, modulo N.
module link_rr_pick
  import link_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = idw_of(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [IDW-1:0] win_o
);

  logic [IDW-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_i) + i) % N);
      if (req_i[idx]) begin
        any_o = 1'b1;
        win_o = idx;
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link between N requesters.
// state   | meaning
// IDLE    | no grant; arbitrate when m_ack is low and any s_req is set
// REQ     | m_req high to slave, waiting for m_ack
// ACKED   | winner acked, waiting for winner to drop s_req
// RELEASE | m_req low, waiting for slave to drop m_ack
module link_arbiter
  import link_pkg::*;
#(
  parameter int N   = 2,
  parameter int DW  = DW_DEFAULT,
  parameter int IDW = idw_of(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_req,
  input  logic [N*DW-1:0] s_data,
  output logic [N-1:0]    s_ack,
  output logic            m_req,
  output logic [DW-1:0]   m_data,
  input  logic            m_ack,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [15:0]     xfer_count
);

  link_state_e    state_q;
  logic [N-1:0]   s_ack_q;
  logic           m_req_q;
  logic [DW-1:0]  m_data_q;
  logic           grant_valid_q;
  logic [IDW-1:0] grant_id_q;
  logic [15:0]    xfer_count_q, xfer_count_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           pick_any;
  logic [IDW-1:0] pick_win;

  link_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i (s_req),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .win_o (pick_win)
  );

  assign rr_ptr_d     = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;
  assign xfer_count_d = xfer_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      s_ack_q       <= '0;
      m_req_q       <= 1'b0;
      m_data_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      xfer_count_q  <= '0;
      rr_ptr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A stale ack from the previous slave cycle blocks new grants.
          if (!m_ack && pick_any) begin
            m_data_q      <= s_data[int'(pick_win) * DW +: DW];
            grant_id_q    <= pick_win;
            grant_valid_q <= 1'b1;
            m_req_q       <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (m_ack) begin
            s_ack_q <= N'(1) << grant_id_q;
            state_q <= ACKED;
          end
        end
        ACKED: begin
          if (!s_req[grant_id_q]) begin
            m_req_q <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!m_ack) begin
            s_ack_q       <= '0;
            grant_valid_q <= 1'b0;
            xfer_count_q  <= xfer_count_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ack       = s_ack_q;
  assign m_req       = m_req_q;
  assign m_data      = m_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign xfer_count  = xfer_count_q;

endmodule
